// File: rtl/mem_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_seq : Neander memory-access sequencer (fetch/execute arbitration,      |
// |           REM/RDM load control, fixed-latency reads).                      |
// | Optional: MEMSEQ_FIXPRIO_EN selects fixed priority (X over F).             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_seq #(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_f,
  input  logic [AW-1:0] addr_f,
  input  logic          req_x,
  input  logic [AW-1:0] addr_x,
  input  logic          we_x,
  input  logic [DW-1:0] wdata_x,
  output logic          gnt_f,
  output logic          gnt_x,
  output logic          done_f,
  output logic          done_x,
  output logic          rem_load,
  output logic [AW-1:0] rem_d,
  output logic          rdm_load,
  output logic [DW-1:0] rdm_d,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_RD_WAIT = 3'd2,
    S_CAPT    = 3'd3,
    S_WR_DATA = 3'd4,
    S_WR_STB  = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [3:0] c_wait_init = 4'(MEM_LAT - 1);

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_own_x;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic            r_rdm_from_mem;
  logic            w_win_x;

`ifdef MEMSEQ_FIXPRIO_EN
  assign w_win_x = req_x;
`else
  logic r_last_x;
  // On a tie the requester that was not granted last wins.
  assign w_win_x = req_x & (~req_f | ~r_last_x);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= 4'd0;
      r_own_x        <= 1'b0;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_rdm_from_mem <= 1'b0;
      gnt_f          <= 1'b0;
      gnt_x          <= 1'b0;
      done_f         <= 1'b0;
      done_x         <= 1'b0;
      rem_load       <= 1'b0;
      rdm_load       <= 1'b0;
      mem_re         <= 1'b0;
      mem_we         <= 1'b0;
`ifndef MEMSEQ_FIXPRIO_EN
      r_last_x       <= 1'b1;
`endif
    end else begin
      gnt_f    <= 1'b0;
      gnt_x    <= 1'b0;
      done_f   <= 1'b0;
      done_x   <= 1'b0;
      rem_load <= 1'b0;
      rdm_load <= 1'b0;
      mem_re   <= 1'b0;
      mem_we   <= 1'b0;
      // Outputs are registered alongside the state they belong to.
      case (r_state)
        S_IDLE: begin
          if (req_f || req_x) begin
            r_state  <= S_ADDR;
            r_own_x  <= w_win_x;
            r_addr   <= w_win_x ? addr_x : addr_f;
            r_we     <= w_win_x & we_x;
            r_wdata  <= wdata_x;
            gnt_x    <= w_win_x;
            gnt_f    <= ~w_win_x;
            rem_load <= 1'b1;
`ifndef MEMSEQ_FIXPRIO_EN
            r_last_x <= w_win_x;
`endif
          end
        end
        S_ADDR: begin
          if (r_we) begin
            r_state        <= S_WR_DATA;
            rdm_load       <= 1'b1;
            r_rdm_from_mem <= 1'b0;
          end else begin
            r_state <= S_RD_WAIT;
            r_cnt   <= c_wait_init;
            mem_re  <= 1'b1;
          end
        end
        S_RD_WAIT: begin
          mem_re <= 1'b1;
          if (r_cnt == 4'd0) begin
            r_state        <= S_CAPT;
            rdm_load       <= 1'b1;
            r_rdm_from_mem <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_CAPT: begin
          r_state <= S_DONE;
          done_f  <= ~r_own_x;
          done_x  <= r_own_x;
        end
        S_WR_DATA: begin
          r_state <= S_WR_STB;
          mem_we  <= 1'b1;
        end
        S_WR_STB: begin
          r_state <= S_DONE;
          done_f  <= ~r_own_x;
          done_x  <= r_own_x;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Data buses are gated so every output is zero outside its load cycle.
  assign rem_d = rem_load ? r_addr : '0;
  assign rdm_d = !rdm_load ? '0 : (r_rdm_from_mem ? mem_rdata : r_wdata);
  assign busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_seq : self-checking bench for mem_seq against a timeline model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_seq;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int LAT = 2;
  localparam int VW  = 9 + AW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_f, req_x, we_x;
  logic [AW-1:0] addr_f, addr_x;
  logic [DW-1:0] wdata_x, mem_rdata;
  logic          gnt_f, gnt_x, done_f, done_x, rem_load, rdm_load, mem_re, mem_we, busy;
  logic [AW-1:0] rem_d;
  logic [DW-1:0] rdm_d;

  int checks = 0;
  int errors = 0;

  mem_seq #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_f(req_f), .addr_f(addr_f),
    .req_x(req_x), .addr_x(addr_x), .we_x(we_x), .wdata_x(wdata_x),
    .gnt_f(gnt_f), .gnt_x(gnt_x), .done_f(done_f), .done_x(done_x),
    .rem_load(rem_load), .rem_d(rem_d), .rdm_load(rdm_load), .rdm_d(rdm_d),
    .mem_rdata(mem_rdata), .mem_re(mem_re), .mem_we(mem_we), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [VW-1:0] obs;
  assign obs = {gnt_f, gnt_x, done_f, done_x, rem_load, rem_d, rdm_load, rdm_d,
                mem_re, mem_we, busy};

  // Reference model: an access is a timeline of offsets k=1.. after its sampling edge.
  bit            m_act;
  int            m_k;
  bit            m_x, m_we, m_last_x;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  function automatic int done_k();
    return m_we ? 4 : LAT + 3;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    bit g, dl, re, wr, dn;
    logic [AW-1:0] ad;
    logic [DW-1:0] dd;
    if (!m_act) return '0;
    g  = (m_k == 1);
    ad = g ? m_addr : '0;
    if (m_we) begin
      dl = (m_k == 2);
      dd = dl ? m_wdata : '0;
      re = 1'b0;
      wr = (m_k == 3);
    end else begin
      dl = (m_k == LAT + 2);
      dd = dl ? mem_rdata : '0;
      re = (m_k >= 2) && (m_k <= LAT + 2);
      wr = 1'b0;
    end
    dn = (m_k == done_k());
    return {g & ~m_x, g & m_x, dn & ~m_x, dn & m_x, g, ad, dl, dd, re, wr, 1'b1};
  endfunction

  task automatic model_adv();
    bit wx;
    if (!rst) begin
      m_act = 0;
      m_last_x = 1;
    end else if (m_act) begin
      if (m_k == done_k()) m_act = 0;
      else m_k++;
    end else if (req_f || req_x) begin
`ifdef MEMSEQ_FIXPRIO_EN
      wx = req_x;
`else
      wx = (req_f && req_x) ? !m_last_x : req_x;
`endif
      m_act = 1; m_k = 1; m_x = wx;
      m_addr = wx ? addr_x : addr_f;
      m_we = wx && we_x;
      m_wdata = wdata_x;
      m_last_x = wx;
    end
  endtask

  task automatic test_reset();
    logic [VW-1:0] e;
    for (int i = 0; i < 3; i++) begin
      rst = 1'b0; req_f = 1'b1; req_x = 1'b1; we_x = 1'b1;
      @(negedge clk);
      e = exp_vec();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL reset cyc %0d got %h expected %h", i, obs, e); end
      model_adv();
      @(posedge clk); #1;
    end
    rst = 1'b1; req_f = 1'b0; req_x = 1'b0; we_x = 1'b0;
  endtask

  task automatic test_single_read();
    logic [VW-1:0] e;
    int re_cnt = 0, dn_at = -1, ld_at = -1;
    mem_rdata = 16'hBEEF;
    for (int i = 0; i < LAT + 6; i++) begin
      req_f = (i == 0); addr_f = 8'h2A;
      @(negedge clk);
      e = exp_vec();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL single_read cyc %0d got %h expected %h", i, obs, e); end
      if (mem_re) re_cnt++;
      if (done_f) dn_at = i;
      if (rdm_load) begin
        ld_at = i;
        checks++;
        if (rdm_d !== 16'hBEEF) begin errors++; $display("FAIL read_rdm_d got %h expected beef", rdm_d); end
      end
      model_adv();
      @(posedge clk); #1;
    end
    checks++;
    if (re_cnt != LAT + 1) begin errors++; $display("FAIL read_re_cycles got %0d expected %0d", re_cnt, LAT + 1); end
    checks++;
    if (dn_at != LAT + 3 || ld_at != LAT + 2) begin
      errors++; $display("FAIL read_latency done %0d load %0d expected %0d %0d", dn_at, ld_at, LAT + 3, LAT + 2);
    end
  endtask

  task automatic test_single_write();
    logic [VW-1:0] e;
    int re_cnt = 0, we_at = -1, dn_at = -1;
    for (int i = 0; i < 7; i++) begin
      req_x = (i == 0); addr_x = 8'h05; we_x = 1'b1; wdata_x = 16'h1234;
      mem_rdata = DW'($urandom);
      @(negedge clk);
      e = exp_vec();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL single_write cyc %0d got %h expected %h", i, obs, e); end
      if (mem_re) re_cnt++;
      if (mem_we) we_at = (we_at == -1) ? i : 99;
      if (done_x) dn_at = i;
      model_adv();
      @(posedge clk); #1;
    end
    we_x = 1'b0;
    checks++;
    if (re_cnt != 0 || we_at != 3 || dn_at != 4) begin
      errors++; $display("FAIL write_timing re %0d we_at %0d done_at %0d expected 0 3 4", re_cnt, we_at, dn_at);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [VW-1:0] e;
    int dn_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      req_f = (i == 0); addr_f = 8'h10; rst = !(i == 3);
      @(negedge clk);
      e = exp_vec();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_mid_read cyc %0d got %h expected %h", i, obs, e); end
      if (done_f) dn_cnt++;
      if (i == 4) begin
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_mid_idle got %h expected 0", obs); end
      end
      model_adv();
      @(posedge clk); #1;
    end
    rst = 1'b1;
    checks++;
    if (dn_cnt != 0) begin errors++; $display("FAIL reset_mid_done got %0d pulses expected 0", dn_cnt); end
  endtask

  task automatic test_round_robin();
    logic [VW-1:0] e;
    logic [2:0] seq = '0, want;
    int n = 0;
`ifdef MEMSEQ_FIXPRIO_EN
    want = 3'b111;
`else
    want = 3'b010;
`endif
    rst = 1'b0;
    @(negedge clk); model_adv(); @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 60 && (n < 3 || m_act); i++) begin
      req_f = (n < 3); req_x = (n < 3); addr_f = 8'hA0; addr_x = 8'hB0; we_x = 1'b0;
      @(negedge clk);
      e = exp_vec();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL tie cyc %0d got %h expected %h", i, obs, e); end
      if ((gnt_f || gnt_x) && n < 3) begin seq[2-n] = gnt_x; n++; end
      model_adv();
      @(posedge clk); #1;
    end
    req_f = 1'b0; req_x = 1'b0;
    checks++;
    if (n != 3 || seq !== want) begin
      errors++; $display("FAIL tie_order got %b (%0d grants) expected %b (1=X)", seq, n, want);
    end
  endtask

  task automatic test_early_drop();
    logic [VW-1:0] e;
    int dn_at = -1;
    for (int i = 0; i < LAT + 6; i++) begin
      req_x = (i == 0); addr_x = 8'h77; we_x = (i == 0) ? 1'b0 : 1'b1;
      mem_rdata = DW'($urandom);
      @(negedge clk);
      e = exp_vec();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL early_drop cyc %0d got %h expected %h", i, obs, e); end
      if (done_x) dn_at = i;
      model_adv();
      @(posedge clk); #1;
    end
    we_x = 1'b0;
    checks++;
    if (dn_at != LAT + 3) begin errors++; $display("FAIL early_drop_done got %0d expected %0d", dn_at, LAT + 3); end
  endtask

  task automatic test_random();
    logic [VW-1:0] e;
    bit sf = 0, sx = 0;
    for (int i = 0; i < 400; i++) begin
      // Requests stay stable until granted, then may drop or re-request.
      if (!req_f || sf) begin
        req_f = ($urandom_range(0, 2) == 0);
        addr_f = AW'($urandom);
      end
      if (!req_x || sx) begin
        req_x = ($urandom_range(0, 2) == 0);
        addr_x = AW'($urandom); we_x = 1'($urandom); wdata_x = DW'($urandom);
      end
      mem_rdata = DW'($urandom);
      rst = ($urandom_range(0, 99) != 0);
      @(negedge clk);
      e = exp_vec();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL random cyc %0d got %h expected %h", i, obs, e); end
      sf = gnt_f; sx = gnt_x;
      model_adv();
      @(posedge clk); #1;
    end
    rst = 1'b1; req_f = 1'b0; req_x = 1'b0;
    for (int i = 0; i < LAT + 6; i++) begin
      @(negedge clk);
      e = exp_vec();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL drain cyc %0d got %h expected %h", i, obs, e); end
      model_adv();
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b0; req_f = 1'b0; req_x = 1'b0; we_x = 1'b0;
    addr_f = '0; addr_x = '0; wdata_x = '0; mem_rdata = '0;
    m_act = 0; m_k = 0; m_x = 0; m_we = 0; m_last_x = 1; m_addr = '0; m_wdata = '0;
    @(posedge clk); #1;
    test_reset();
    test_single_read();
    test_single_write();
    test_reset_mid_read();
    test_round_robin();
    test_early_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_seq.md
Name: mem_seq

Overview:
- Memory-access sequencer for the Neander datapath.
- Arbitrates between two requesters: instruction fetch (F, read-only) and execute (X, read or write).
- Drives the address register (REM) load, the data register (RDM) load and data select, and the memory read/write strobes.
- Enforces a fixed memory read latency so RDM always captures valid data.

Parameters:
- AW, 8, address width (REM width).
- DW, 16, data width (RDM width).
- MEM_LAT, 2, memory read latency in cycles; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset.
- req_f  in  1  fetch read request.
- addr_f  in  AW  fetch address.
- req_x  in  1  execute request.
- addr_x  in  AW  execute address.
- we_x  in  1  execute access type: 1 = write, 0 = read.
- wdata_x  in  DW  execute write data.
- gnt_f, gnt_x  out  1  one-cycle grant pulses.
- done_f, done_x  out  1  one-cycle completion pulses; for reads, RDM holds the data when done is asserted.
- rem_load  out  1  REM load enable.
- rem_d  out  AW  REM input.
- rdm_load  out  1  RDM load enable.
- rdm_d  out  DW  RDM input.
- mem_rdata  in  DW  memory read data.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (already decided): one clock, clk; reset port rst is synchronous and active-low.
  - rst=0 at a rising edge forces state IDLE, wait counter 0, owner F, last grant X.
  - All outputs are 0 while in IDLE with no request.
  - rst wins over every other event, including mid-access. An aborted access never produces done.
- Outputs are decoded from registered state/owner/latched request. There is no combinational path from req_* to any output.
- IDLE, arbitration:
  - If any request is high, pick a winner.
  - Latch the winner id, its address, we (forced 0 for F) and wdata into internal registers.
  - Go to ADDR.
  - Requesters must hold req/addr/we/wdata stable only until their gnt. Deasserting req after the IDLE sampling edge does not cancel the access.
- Arbitration without the optional feature: round-robin.
  - If both requesters are high, the one not granted last wins.
  - Last grant resets to X, so F wins the first tie.
  - A single requester always wins.
- ADDR (1 cycle): rem_load=1, rem_d=latched addr, gnt_owner=1. Next state is RD_WAIT if read, WR_DATA if write.
- RD_WAIT (MEM_LAT cycles):
  - mem_re=1.
  - Counter loads MEM_LAT-1 on entry and decrements each cycle; leave when it reaches 0.
  - Next state CAPT.
- CAPT (1 cycle): mem_re=1, rdm_load=1, rdm_d=mem_rdata. Next state DONE.
- WR_DATA (1 cycle): rdm_load=1, rdm_d=latched wdata. Next state WR_STB.
- WR_STB (1 cycle): mem_we=1; memory writes using REM/RDM contents. Next state DONE.
- DONE (1 cycle): done_owner=1. Always returns to IDLE, so there is at least one IDLE cycle between accesses.
- Latency, counting request sampled in IDLE at cycle T:
  - Read: gnt at T+1, rdm_load at T+2+MEM_LAT, done at T+3+MEM_LAT.
  - Write: gnt at T+1, mem_we at T+3, done at T+4.
- Exclusivity rules:
  - mem_re and mem_we are never high together.
  - gnt_f/gnt_x are mutually exclusive; so are done_f/done_x.
  - rdm_load is never asserted outside CAPT/WR_DATA.
- A request arriving while busy waits in its requester; it is not queued internally.
- A requester still holding req during DONE is re-arbitrated in the following IDLE.

Optional Feature:
- Macro: MEMSEQ_FIXPRIO_EN.
- Defined: fixed priority, X always beats F on a tie; the last-grant register is unused.
- Undefined: round-robin as specified above.
- All other timing is identical in both builds.

Test Plan:
- Reset mid-read: F read addr 0x10 starts, rst=0 during RD_WAIT → next cycle state IDLE, all outputs 0, no done_f, busy=0.
- Single read: F read addr 0x2A, MEM_LAT=2, mem_rdata=0xBEEF → gnt_f at T+1, rem_d=0x2A with rem_load at T+1, mem_re high T+2..T+4, rdm_d=0xBEEF with rdm_load at T+4, done_f at T+5.
- Single write: X write addr 0x05, wdata 0x1234 → rem_load rem_d=0x05 at T+1, rdm_load rdm_d=0x1234 at T+2, mem_we at T+3 only, done_x at T+4, mem_re never high.
- Round-robin tie: F and X both held high for three accesses → grants F, X, F. With MEMSEQ_FIXPRIO_EN defined → X, X, X.
- Early request drop: X read requested at T, req_x dropped at T+1 → access completes normally, done_x at T+3+MEM_LAT.
- MEM_LAT=1 build: F read → mem_re high for exactly 2 cycles (RD_WAIT+CAPT), done_f at T+4.
